// File: rtl/hash_job_sequencer.sv
// Sequences one hash job: broadcast work to all macros, seed nonces, then
// round-robin service of DATA_AVAILABLE flags with result bytes streamed out.
module hash_job_sequencer #(
    parameter int          NUM_OF_MACROS = 2,
    parameter int          IDX_WIDTH     = 1,
    parameter int          WORK_BYTES    = 44,
    parameter logic [5:0]  NONCE_ADDR    = 6'h2C,
    parameter logic [5:0]  RESULT_ADDR   = 6'h30,
    parameter int          RESULT_BYTES  = 4,
    parameter int          RD_LATENCY    = 2
) (
    input  logic                     M1_CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     work_valid,
    input  logic [7:0]               work_data,
    output logic                     work_ready,
    output logic [NUM_OF_MACROS-1:0] macro_wr_sel,
    output logic [NUM_OF_MACROS-1:0] macro_rd_sel,
    output logic [5:0]               macro_addr,
    output logic [7:0]               macro_wdata,
    output logic                     hash_en,
    input  logic [NUM_OF_MACROS-1:0] macro_irq,
    input  logic [7:0]               macro_rd_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [7:0]               res_data,
    output logic [IDX_WIDTH-1:0]     res_macro,
    output logic                     res_last,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_OF_MACROS-1:0] serviced
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEED, S_RUN, S_READ, S_EMIT, S_DONE
    } state_t;

    state_t                   state;
    logic [5:0]               byte_cnt;
    logic [IDX_WIDTH-1:0]     seed_idx;
    logic [IDX_WIDTH-1:0]     ptr;
    logic [IDX_WIDTH-1:0]     grant;
    logic [IDX_WIDTH-1:0]     grant_next;
    logic                     grant_found;
    logic [NUM_OF_MACROS-1:0] pending;
    logic [IDX_WIDTH:0]       cand;
    logic [7:0]               lat_cnt;
    logic [7:0]               res_cnt;

    // Round-robin: first pending macro strictly after ptr, wrapping.
    always_comb begin
        pending     = macro_irq & ~serviced;
        grant_found = 1'b0;
        grant_next  = '0;
        cand        = '0;
        for (int unsigned off = 1; off <= NUM_OF_MACROS; off++) begin
            cand = {1'b0, ptr} + (IDX_WIDTH+1)'(off);
            if (cand >= (IDX_WIDTH+1)'(NUM_OF_MACROS))
                cand = cand - (IDX_WIDTH+1)'(NUM_OF_MACROS);
            if (!grant_found && pending[cand[IDX_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_next  = cand[IDX_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge M1_CLK) begin
        if (RST) begin
            state        <= S_IDLE;
            work_ready   <= 1'b0;
            macro_wr_sel <= '0;
            macro_rd_sel <= '0;
            macro_addr   <= '0;
            macro_wdata  <= '0;
            hash_en      <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_macro    <= '0;
            res_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            serviced     <= '0;
            byte_cnt     <= '0;
            seed_idx     <= '0;
            ptr          <= IDX_WIDTH'(NUM_OF_MACROS-1);
            grant        <= '0;
            lat_cnt      <= '0;
            res_cnt      <= '0;
        end else if (abort) begin
            // serviced is deliberately left intact until the next start
            state        <= S_IDLE;
            work_ready   <= 1'b0;
            macro_wr_sel <= '0;
            macro_rd_sel <= '0;
            hash_en      <= 1'b0;
            res_valid    <= 1'b0;
            res_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            macro_wr_sel <= '0;
            done         <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state      <= S_LOAD;
                    work_ready <= 1'b1;
                    busy       <= 1'b1;
                    serviced   <= '0;
                    byte_cnt   <= '0;
                end
                S_LOAD: if (work_valid && work_ready) begin
                    macro_wr_sel <= '1;
                    macro_addr   <= byte_cnt;
                    macro_wdata  <= work_data;
                    byte_cnt     <= byte_cnt + 6'd1;
                    if (byte_cnt == 6'(WORK_BYTES-1)) begin
                        work_ready <= 1'b0;
                        seed_idx   <= '0;
                        state      <= S_SEED;
                    end
                end
                S_SEED: begin
                    macro_wr_sel <= NUM_OF_MACROS'(1) << seed_idx;
                    macro_addr   <= NONCE_ADDR;
                    macro_wdata  <= 8'(seed_idx);
                    seed_idx     <= seed_idx + IDX_WIDTH'(1);
                    if (seed_idx == IDX_WIDTH'(NUM_OF_MACROS-1))
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (&serviced) begin
                        hash_en <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        hash_en <= 1'b1;
                        if (grant_found) begin
                            grant        <= grant_next;
                            ptr          <= grant_next;
                            macro_rd_sel <= NUM_OF_MACROS'(1) << grant_next;
                            macro_addr   <= RESULT_ADDR;
                            res_cnt      <= '0;
                            lat_cnt      <= '0;
                            state        <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (lat_cnt == 8'(RD_LATENCY)) begin
                        res_valid <= 1'b1;
                        res_data  <= macro_rd_data;
                        res_macro <= grant;
                        res_last  <= (res_cnt == 8'(RESULT_BYTES-1));
                        state     <= S_EMIT;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                S_EMIT: if (res_ready) begin
                    res_valid <= 1'b0;
                    res_last  <= 1'b0;
                    if (res_cnt == 8'(RESULT_BYTES-1)) begin
                        serviced[grant] <= 1'b1;
                        macro_rd_sel    <= '0;
                        state           <= S_RUN;
                    end else begin
                        res_cnt    <= res_cnt + 8'd1;
                        macro_addr <= macro_addr + 6'd1;
                        lat_cnt    <= '0;
                        state      <= S_READ;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_job_sequencer.sv
// Directed bench for hash_job_sequencer with a two-macro readback model
// (macro 0 returns A0+offset, macro 1 returns B0+offset, 2-cycle latency).
module tb_hash_job_sequencer;

    logic       M1_CLK = 1'b0;
    logic       RST;
    logic       start;
    logic       abort;
    logic       work_valid;
    logic [7:0] work_data;
    logic       work_ready;
    logic [1:0] macro_wr_sel;
    logic [1:0] macro_rd_sel;
    logic [5:0] macro_addr;
    logic [7:0] macro_wdata;
    logic       hash_en;
    logic [1:0] macro_irq;
    logic [7:0] macro_rd_data;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [0:0] res_macro;
    logic       res_last;
    logic       busy;
    logic       done;
    logic [1:0] serviced;

    int checks = 0;
    int errors = 0;

    always #5 M1_CLK = ~M1_CLK;

    hash_job_sequencer #(
        .NUM_OF_MACROS(2),
        .IDX_WIDTH(1),
        .WORK_BYTES(44),
        .NONCE_ADDR(6'h2C),
        .RESULT_ADDR(6'h30),
        .RESULT_BYTES(4),
        .RD_LATENCY(2)
    ) dut (
        .M1_CLK(M1_CLK), .RST(RST), .start(start), .abort(abort),
        .work_valid(work_valid), .work_data(work_data), .work_ready(work_ready),
        .macro_wr_sel(macro_wr_sel), .macro_rd_sel(macro_rd_sel),
        .macro_addr(macro_addr), .macro_wdata(macro_wdata), .hash_en(hash_en),
        .macro_irq(macro_irq), .macro_rd_data(macro_rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_macro(res_macro), .res_last(res_last), .busy(busy), .done(done),
        .serviced(serviced)
    );

    // Macro readback: data for the address in cycle t is presented in cycle t+2
    logic [7:0] p0, p1;
    always @(posedge M1_CLK) begin
        if (macro_rd_sel == 2'b01)      p0 <= 8'hA0 + (8'(macro_addr) - 8'h30);
        else if (macro_rd_sel == 2'b10) p0 <= 8'hB0 + (8'(macro_addr) - 8'h30);
        else                            p0 <= 8'hEE;
        p1 <= p0;
    end
    assign macro_rd_data = p1;

    task automatic tick();
        @(posedge M1_CLK);
        @(negedge M1_CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_job(input int gap_at, input int restart_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ready", 32'(work_ready), 32'd1);
        chk("load_serviced_clr", 32'(serviced), 32'd0);
        work_valid = 1'b1;
        for (int k = 0; k < 44; k++) begin
            if (k == gap_at) begin
                work_valid = 1'b0;
                tick();
                chk("gap_no_write", 32'(macro_wr_sel), 32'd0);
                work_valid = 1'b1;
            end
            if (k == restart_at) start = 1'b1;
            work_data = 8'(k);
            tick();
            start = 1'b0;
            chk("bcast", 32'({macro_wr_sel, macro_addr, macro_wdata}),
                32'({2'b11, 6'(k), 8'(k)}));
        end
        work_valid = 1'b0;
        chk("ready_drop", 32'(work_ready), 32'd0);
        tick();
        chk("seed0", 32'({macro_wr_sel, macro_addr, macro_wdata}), 32'({2'b01, 6'h2C, 8'h00}));
        tick();
        chk("seed1", 32'({macro_wr_sel, macro_addr, macro_wdata}), 32'({2'b10, 6'h2C, 8'h01}));
        tick();
        chk("run_no_write", 32'(macro_wr_sel), 32'd0);
        chk("run_hash_en", 32'(hash_en), 32'd1);
    endtask

    task automatic read_macro(input int m, input int stall_byte);
        logic [1:0] sel;
        logic [7:0] base;
        int n;
        sel  = (m == 0) ? 2'b01 : 2'b10;
        base = (m == 0) ? 8'hA0 : 8'hB0;
        n = 0;
        while (macro_rd_sel == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        for (int b = 0; b < 4; b++) begin
            chk("rd_sel", 32'(macro_rd_sel), 32'(sel));
            chk("rd_addr", 32'(macro_addr), 32'h30 + 32'(b));
            chk("hash_en_read", 32'(hash_en), 32'd1);
            tick();
            tick();
            chk("latency_gap", 32'(res_valid), 32'd0);
            tick();
            chk("res_valid", 32'(res_valid), 32'd1);
            chk("res_data", 32'(res_data), 32'(base) + 32'(b));
            chk("res_macro", 32'(res_macro), 32'(m));
            chk("res_last", 32'(res_last), (b == 3) ? 32'd1 : 32'd0);
            if (b == stall_byte) begin
                res_ready = 1'b0;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    chk("stall_valid", 32'(res_valid), 32'd1);
                    chk("stall_data", 32'(res_data), 32'(base) + 32'(b));
                    chk("stall_addr", 32'(macro_addr), 32'h30 + 32'(b));
                end
                res_ready = 1'b1;
            end
            tick();
        end
        chk("rd_sel_release", 32'(macro_rd_sel), 32'd0);
        chk("serviced_bit", 32'(serviced[m]), 32'd1);
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; abort = 1'b0; work_valid = 1'b0;
        work_data = '0; macro_irq = '0; res_ready = 1'b1;
        repeat (2) tick();
        RST = 1'b0;
        chk("rst_outputs", 32'({busy, hash_en, work_ready, macro_wr_sel, macro_rd_sel,
                                res_valid, done, serviced}), 32'd0);
        chk("rst_data", 32'({macro_addr, macro_wdata, res_data, res_last, res_macro}), 32'd0);

        // Broadcast load with one idle gap, then nonce seeds
        load_job(5, -1);

        // Macro 0 alone, then idle RUN
        macro_irq = 2'b01;
        read_macro(0, -1);
        macro_irq = 2'b00;
        chk("serviced_01", 32'(serviced), 32'b01);
        tick();
        chk("run_idle_rd", 32'(macro_rd_sel), 32'd0);
        chk("run_idle_busy", 32'(busy), 32'd1);

        // Macro 1 with 10 cycles of backpressure on byte 2, then completion
        macro_irq = 2'b10;
        read_macro(1, 2);
        macro_irq = 2'b00;
        tick();
        chk("done_pulse", 32'({done, hash_en, busy}), 32'b101);
        tick();
        chk("done_clear", 32'({done, hash_en, busy}), 32'b000);

        // Simultaneous irqs: macro 0 then macro 1
        load_job(-1, -1);
        macro_irq = 2'b11;
        read_macro(0, -1);
        read_macro(1, -1);
        macro_irq = 2'b00;
        tick();
        chk("done_pulse2", 32'({done, hash_en, busy}), 32'b101);
        tick();
        chk("idle_after2", 32'({done, hash_en, busy}), 32'b000);
        tick();
        chk("done_once", 32'(done), 32'd0);

        // Abort during LOAD after 10 bytes
        start = 1'b1;
        tick();
        start = 1'b0;
        work_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            work_data = 8'h40 + 8'(k);
            tick();
        end
        chk("partial_write", 32'({macro_wr_sel, macro_addr, macro_wdata}), 32'({2'b11, 6'd9, 8'h49}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        work_valid = 1'b0;
        chk("abort_load", 32'({macro_wr_sel, macro_rd_sel, work_ready, hash_en, res_valid, busy}), 32'd0);

        // Reload from address 0, then abort mid-stream
        load_job(-1, -1);
        macro_irq = 2'b01;
        read_macro(0, -1);
        macro_irq = 2'b10;
        for (int n = 0; n < 20 && macro_rd_sel == 2'b00; n++) tick();
        chk("emit_grant", 32'(macro_rd_sel), 32'b10);
        repeat (3) tick();
        chk("emit_byte0", 32'({res_valid, res_data}), 32'({1'b1, 8'hB0}));
        res_ready = 1'b0;
        tick();
        chk("emit_hold", 32'(res_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        res_ready = 1'b1;
        macro_irq = 2'b00;
        chk("abort_emit", 32'({macro_wr_sel, macro_rd_sel, work_ready, hash_en, res_valid, busy}), 32'd0);
        chk("abort_keep_serviced", 32'(serviced), 32'b01);
        tick();
        chk("idle_keep_serviced", 32'({busy, serviced}), 32'b001);

        // start while busy is ignored (in LOAD and in RUN)
        load_job(-1, 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_run", 32'({busy, hash_en, work_ready, macro_wr_sel}), 32'b11000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run", 32'({busy, hash_en}), 32'd0);

        // start and abort together in IDLE: stays idle, no LOAD writes
        start = 1'b1;
        abort = 1'b1;
        work_valid = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", 32'({busy, work_ready, macro_wr_sel}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_load", 32'({busy, work_ready, macro_wr_sel}), 32'd0);
        end
        work_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
